// File: rtl/mux_demux_pkg.sv
// Shared definitions for the 4:1 valid/data mux and its 1:4 demux counterpart.
// Lane indices are sized so they wrap 3 -> 0 on their own.
package mux_demux_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int NUM_LANES  = 4;
  localparam int LANE_W     = 2;

  typedef logic [LANE_W-1:0] lane_idx_t;

  function automatic lane_idx_t next_lane(input lane_idx_t cur);
    return cur + lane_idx_t'(1);
  endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry output register for a single demux lane with valid/ready handshake.
// A load in the same cycle as a drain wins, so a busy lane streams without bubbles.
module demux_lane_reg #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              can_load
);

  assign can_load = ~valid | ready;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_14.sv
// Round-robin 1:4 demultiplexer: successive accepted words go to lanes 0,1,2,3,0,...
// A full, stalled lane blocks the input; rotation never skips ahead to a free lane.
module demux_14
  import mux_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [DATA_W-1:0] data_0,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  output logic [DATA_W-1:0] data_3,
  output logic              valid_0,
  output logic              valid_1,
  output logic              valid_2,
  output logic              valid_3,
  input  logic              ready_0,
  input  logic              ready_1,
  input  logic              ready_2,
  input  logic              ready_3,
  output logic [LANE_W-1:0] lane_sel
);

  logic [NUM_LANES-1:0] lane_ready;
  logic [NUM_LANES-1:0] lane_load;
  logic [NUM_LANES-1:0] lane_valid;
  logic [NUM_LANES-1:0] lane_can_load;
  logic [DATA_W-1:0]    lane_data [NUM_LANES];
  logic                 accept;

  assign lane_ready = {ready_3, ready_2, ready_1, ready_0};

  // ready_in follows the selected lane only; ready_N -> ready_in is combinational.
  assign ready_in = lane_can_load[lane_sel];
  assign accept   = valid_in & ready_in;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      lane_sel <= '0;
    end else if (accept) begin
      lane_sel <= next_lane(lane_sel);
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_load[i] = accept && (lane_sel == lane_idx_t'(i));

    demux_lane_reg #(
      .DATA_W(DATA_W)
    ) u_lane (
      .clk     (clk),
      .reset_L (reset_L),
      .load    (lane_load[i]),
      .din     (data_in),
      .ready   (lane_ready[i]),
      .data    (lane_data[i]),
      .valid   (lane_valid[i]),
      .can_load(lane_can_load[i])
    );
  end

  assign data_0  = lane_data[0];
  assign data_1  = lane_data[1];
  assign data_2  = lane_data[2];
  assign data_3  = lane_data[3];
  assign valid_0 = lane_valid[0];
  assign valid_1 = lane_valid[1];
  assign valid_2 = lane_valid[2];
  assign valid_3 = lane_valid[3];

endmodule

// File: tb/tb_demux_14.sv
// Self-checking bench for demux_14: directed scenarios plus a randomized
// run checked against a per-lane scoreboard filled at accept time.
module tb_demux_14;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [3:0] data_in;
  logic       valid_in;
  logic       ready_in;
  logic [3:0] data_0, data_1, data_2, data_3;
  logic       valid_0, valid_1, valid_2, valid_3;
  logic       ready_0, ready_1, ready_2, ready_3;
  logic [1:0] lane_sel;

  logic [3:0] rdy;
  logic [3:0] dv;
  logic [3:0] dd [4];

  int checks = 0;
  int errors = 0;

  logic [3:0] sb_q [4][$];
  logic [1:0] m_sel;
  logic [3:0] m_valid;

  assign ready_0 = rdy[0];
  assign ready_1 = rdy[1];
  assign ready_2 = rdy[2];
  assign ready_3 = rdy[3];
  assign dv      = {valid_3, valid_2, valid_1, valid_0};
  assign dd[0]   = data_0;
  assign dd[1]   = data_1;
  assign dd[2]   = data_2;
  assign dd[3]   = data_3;

  always #5 clk = ~clk;

  demux_14 #(.DATA_W(4)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .data_in (data_in),
    .valid_in(valid_in),
    .ready_in(ready_in),
    .data_0  (data_0),
    .data_1  (data_1),
    .data_2  (data_2),
    .data_3  (data_3),
    .valid_0 (valid_0),
    .valid_1 (valid_1),
    .valid_2 (valid_2),
    .valid_3 (valid_3),
    .ready_0 (ready_0),
    .ready_1 (ready_1),
    .ready_2 (ready_2),
    .ready_3 (ready_3),
    .lane_sel(lane_sel)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    valid_in = 1'b0;
    data_in  = 4'h0;
    reset_L  = 1'b0;
    tick();
    reset_L  = 1'b1;
    for (int i = 0; i < 4; i++) sb_q[i].delete();
    m_sel   = 2'd0;
    m_valid = 4'b0000;
  endtask

  // Reference model advance for one posedge, using the inputs currently driven.
  task automatic model_step;
    logic acc;
    acc = valid_in && (!m_valid[m_sel] || rdy[m_sel]);
    for (int i = 0; i < 4; i++)
      if (m_valid[i] && rdy[i]) m_valid[i] = 1'b0;
    if (acc) begin
      m_valid[m_sel] = 1'b1;
      sb_q[m_sel].push_back(data_in);
      m_sel = m_sel + 2'd1;
    end
  endtask

  task automatic test_reset;
    reset_L  = 1'b0;
    valid_in = 1'b1;
    data_in  = 4'hA;
    rdy      = 4'b1111;
    tick();
    tick();
    checks++;
    if (dv !== 4'b0000) begin
      errors++; $display("FAIL reset_valid: got %b expected 0000", dv);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dd[i] !== 4'h0) begin
        errors++; $display("FAIL reset_data%0d: got %h expected 0", i, dd[i]);
      end
    end
    checks++;
    if (lane_sel !== 2'd0) begin
      errors++; $display("FAIL reset_lane_sel: got %0d expected 0", lane_sel);
    end
    reset_L = 1'b1;
    data_in = 4'h7;
    tick();
    checks++;
    if (valid_0 !== 1'b1 || data_0 !== 4'h7 || lane_sel !== 2'd1) begin
      errors++;
      $display("FAIL reset_first_accept: got v0=%b d0=%h sel=%0d expected v0=1 d0=7 sel=1",
               valid_0, data_0, lane_sel);
    end
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_streaming;
    int lane;
    apply_reset();
    rdy = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      valid_in = 1'b1;
      data_in  = 4'(k + 1);
      #1;
      checks++;
      if (ready_in !== 1'b1) begin
        errors++; $display("FAIL stream_ready_in: word %0d got %b expected 1", k + 1, ready_in);
      end
      tick();
      lane = k % 4;
      checks++;
      if (dv !== 4'(1 << lane) || dd[lane] !== 4'(k + 1) || lane_sel !== 2'((k + 1) % 4)) begin
        errors++;
        $display("FAIL stream_word%0d: got valid=%b data=%h sel=%0d expected valid=%b data=%h sel=%0d",
                 k + 1, dv, dd[lane], lane_sel, 4'(1 << lane), 4'(k + 1), (k + 1) % 4);
      end
    end
    valid_in = 1'b0;
    tick();
    checks++;
    if (dv !== 4'b0000) begin
      errors++; $display("FAIL stream_drained: got %b expected 0000", dv);
    end
  endtask

  task automatic test_backpressure;
    apply_reset();
    rdy = 4'b1101;
    for (int k = 1; k <= 5; k++) begin
      valid_in = 1'b1;
      data_in  = 4'(k);
      tick();
    end
    checks++;
    if (valid_0 !== 1'b1 || data_0 !== 4'h5 || lane_sel !== 2'd1) begin
      errors++;
      $display("FAIL bp_lane0_reload: got v0=%b d0=%h sel=%0d expected v0=1 d0=5 sel=1",
               valid_0, data_0, lane_sel);
    end
    data_in = 4'h6;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ready_in !== 1'b0) begin
        errors++; $display("FAIL bp_stall_ready_in: cycle %0d got %b expected 0", c, ready_in);
      end
      tick();
      checks++;
      if (lane_sel !== 2'd1 || valid_1 !== 1'b1 || data_1 !== 4'h2) begin
        errors++;
        $display("FAIL bp_stall_hold: cycle %0d got sel=%0d v1=%b d1=%h expected sel=1 v1=1 d1=2",
                 c, lane_sel, valid_1, data_1);
      end
    end
    rdy = 4'b1111;
    #1;
    checks++;
    if (ready_in !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready_in: got %b expected 1", ready_in);
    end
    tick();
    checks++;
    if (valid_1 !== 1'b1 || data_1 !== 4'h6 || lane_sel !== 2'd2) begin
      errors++;
      $display("FAIL bp_drain_load: got v1=%b d1=%h sel=%0d expected v1=1 d1=6 sel=2",
               valid_1, data_1, lane_sel);
    end
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_gaps;
    logic       v_seq   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] d_seq   [4] = '{4'hF, 4'h0, 4'hE, 4'h0};
    logic [1:0] sel_exp [4] = '{2'd1, 2'd1, 2'd2, 2'd2};
    apply_reset();
    rdy = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      valid_in = v_seq[k];
      data_in  = d_seq[k];
      tick();
      checks++;
      if (lane_sel !== sel_exp[k]) begin
        errors++; $display("FAIL gaps_lane_sel%0d: got %0d expected %0d", k, lane_sel, sel_exp[k]);
      end
    end
    checks++;
    if (dv !== 4'b0011 || data_0 !== 4'hF || data_1 !== 4'hE) begin
      errors++;
      $display("FAIL gaps_lanes: got valid=%b d0=%h d1=%h expected valid=0011 d0=f d1=e",
               dv, data_0, data_1);
    end
    rdy = 4'b1111;
    tick();
  endtask

  task automatic test_mid_reset;
    apply_reset();
    rdy = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      valid_in = 1'b1;
      data_in  = 4'(k);
      tick();
    end
    valid_in = 1'b0;
    checks++;
    if (dv !== 4'b0111) begin
      errors++; $display("FAIL midrst_fill: got %b expected 0111", dv);
    end
    #2 reset_L = 1'b0;
    #1;
    checks++;
    if (dv !== 4'b0000 || data_0 !== 4'h0 || data_1 !== 4'h0 || data_2 !== 4'h0 || lane_sel !== 2'd0) begin
      errors++;
      $display("FAIL midrst_clear: got valid=%b d0=%h d1=%h d2=%h sel=%0d expected all 0",
               dv, data_0, data_1, data_2, lane_sel);
    end
    #2 reset_L = 1'b1;
    valid_in = 1'b1;
    data_in  = 4'h9;
    tick();
    checks++;
    if (dv !== 4'b0001 || data_0 !== 4'h9 || lane_sel !== 2'd1) begin
      errors++;
      $display("FAIL midrst_next: got valid=%b d0=%h sel=%0d expected valid=0001 d0=9 sel=1",
               dv, data_0, lane_sel);
    end
    valid_in = 1'b0;
    rdy = 4'b1111;
    tick();
  endtask

  task automatic test_random;
    logic [3:0] held;
    logic [3:0] held_data [4];
    logic [3:0] exp_word;
    logic       exp_rin;
    apply_reset();
    held = 4'b0000;
    for (int c = 0; c < 208; c++) begin
      if (c < 200) begin
        valid_in = 1'($urandom_range(1));
        data_in  = 4'($urandom_range(15));
        for (int i = 0; i < 4; i++) rdy[i] = ($urandom_range(9) < 6);
      end else begin
        valid_in = 1'b0;
        rdy      = 4'b1111;
      end
      #1;
      exp_rin = !m_valid[m_sel] || rdy[m_sel];
      checks++;
      if (ready_in !== exp_rin || dv !== m_valid || lane_sel !== m_sel) begin
        errors++;
        $display("FAIL rand_state c%0d: got rin=%b valid=%b sel=%0d expected rin=%b valid=%b sel=%0d",
                 c, ready_in, dv, lane_sel, exp_rin, m_valid, m_sel);
      end
      for (int i = 0; i < 4; i++) begin
        if (held[i]) begin
          checks++;
          if (dv[i] !== 1'b1 || dd[i] !== held_data[i]) begin
            errors++;
            $display("FAIL rand_stable c%0d lane%0d: got v=%b d=%h expected v=1 d=%h",
                     c, i, dv[i], dd[i], held_data[i]);
          end
        end
        if (dv[i] && rdy[i]) begin
          checks++;
          if (sb_q[i].size() == 0) begin
            errors++; $display("FAIL rand_dup c%0d lane%0d: got %h expected no word", c, i, dd[i]);
          end else begin
            exp_word = sb_q[i].pop_front();
            if (dd[i] !== exp_word) begin
              errors++; $display("FAIL rand_data c%0d lane%0d: got %h expected %h", c, i, dd[i], exp_word);
            end
          end
        end
        held[i]      = dv[i] && !rdy[i];
        held_data[i] = dd[i];
      end
      model_step();
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sb_q[i].size() != 0) begin
        errors++; $display("FAIL rand_loss lane%0d: got %0d pending expected 0", i, sb_q[i].size());
      end
    end
  endtask

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 4'h0;
    rdy      = 4'b0000;
    test_reset();
    test_streaming();
    test_backpressure();
    test_gaps();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
